axis_insert_arbiter: RTL and testbench

AXIS_INSERT_ARBITER -- requirements
Module: axis_insert_arbiter

---
 rtl/axis_hdr_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 38 +++
 rtl/axis_insert_arbiter.sv | 149 ++++++++++++++
 tb/tb_axis_insert_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_hdr_pkg.sv
// ---------------------------------------------------------------------------
// axis_hdr_pkg
// Shared definitions for the header-insert arbitration path:
//   arb_state_e  - arbiter FSM state encoding (IDLE -> HEADER -> PAYLOAD)
//   DEF_DATA_WD  - default data/header width in bits
//   DEF_NUM_SRC  - default number of requesters
// ---------------------------------------------------------------------------
package axis_hdr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2
  } arb_state_e;

  localparam int DEF_DATA_WD = 32;
  localparam int DEF_NUM_SRC = 2;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: grants the first requesting index at or
// after ptr, wrapping cyclically.
//   req [N-1:0]          - request vector
//   ptr [$clog2(N)-1:0]  - highest-priority index
//   gnt [N-1:0]          - one-hot grant, zero when no request
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt
);

  logic found;

  // Two passes replace modulo arithmetic: first look at indices >= ptr,
  // then wrap around to the low indices.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_insert_arbiter.sv
// ---------------------------------------------------------------------------
// axis_insert_arbiter
// Round-robin arbiter that selects one of NUM_SRC (header, payload) stream
// pairs and passes the winner through to a single header-insert stage.
// A packet is owned from header acceptance through the payload last beat;
// both channels pass through combinationally (no buffering).
//
// Ports
//   clk, rst_n                     - clock, async active-low reset
//   s_valid/header/keep_insert     - per-source header channels (slice i)
//   s_ready_insert                 - per-source header ready
//   s_valid/data/keep/last_in      - per-source payload channels (slice i)
//   s_ready_in                     - per-source payload ready
//   m_valid/header/keep_insert     - selected header channel
//   m_ready_insert                 - header ready from downstream
//   m_valid/data/keep/last_in      - selected payload channel
//   m_ready_in                     - payload ready from downstream
//   grant                          - registered one-hot owner, 0 when idle
//   state_dbg                      - current FSM state (arb_state_e)
//
// Handshake: a beat transfers on a rising edge where valid and ready are
// both high; valid never depends on ready, and ready is only ever raised
// for the selected source in the phase that owns that channel.
// ---------------------------------------------------------------------------
module axis_insert_arbiter
  import axis_hdr_pkg::*;
#(
  parameter int DATA_WD      = DEF_DATA_WD,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int NUM_SRC      = DEF_NUM_SRC
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_SRC-1:0]              s_valid_insert,
  input  logic [NUM_SRC*DATA_WD-1:0]      s_header_insert,
  input  logic [NUM_SRC*DATA_BYTE_WD-1:0] s_keep_insert,
  output logic [NUM_SRC-1:0]              s_ready_insert,
  input  logic [NUM_SRC-1:0]              s_valid_in,
  input  logic [NUM_SRC*DATA_WD-1:0]      s_data_in,
  input  logic [NUM_SRC*DATA_BYTE_WD-1:0] s_keep_in,
  input  logic [NUM_SRC-1:0]              s_last_in,
  output logic [NUM_SRC-1:0]              s_ready_in,
  output logic                            m_valid_insert,
  output logic [DATA_WD-1:0]              m_header_insert,
  output logic [DATA_BYTE_WD-1:0]         m_keep_insert,
  input  logic                            m_ready_insert,
  output logic                            m_valid_in,
  output logic [DATA_WD-1:0]              m_data_in,
  output logic [DATA_BYTE_WD-1:0]         m_keep_in,
  output logic                            m_last_in,
  input  logic                            m_ready_in,
  output logic [NUM_SRC-1:0]              grant,
  output logic [1:0]                      state_dbg
);

  localparam int SEL_W = $clog2(NUM_SRC);

  arb_state_e         state, state_nxt;
  logic [SEL_W-1:0]   sel, sel_nxt;
  logic [SEL_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [NUM_SRC-1:0] grant_nxt;
  logic [NUM_SRC-1:0] arb_gnt;
  logic [SEL_W-1:0]   arb_idx;

  rr_arbiter #(.N(NUM_SRC)) u_rr_arbiter (
    .req (s_valid_insert),
    .ptr (rr_ptr),
    .gnt (arb_gnt)
  );

  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (arb_gnt[i]) arb_idx = SEL_W'(i);
    end
  end

  // Selected-source pass-through. Data fields always follow sel; only the
  // valids and readies are gated by phase.
  always_comb begin
    m_header_insert = s_header_insert[int'(sel)*DATA_WD +: DATA_WD];
    m_keep_insert   = s_keep_insert[int'(sel)*DATA_BYTE_WD +: DATA_BYTE_WD];
    m_data_in       = s_data_in[int'(sel)*DATA_WD +: DATA_WD];
    m_keep_in       = s_keep_in[int'(sel)*DATA_BYTE_WD +: DATA_BYTE_WD];
    m_last_in       = s_last_in[sel];
    m_valid_insert  = 1'b0;
    m_valid_in      = 1'b0;
    s_ready_insert  = '0;
    s_ready_in      = '0;
    case (state)
      ST_HEADER: begin
        m_valid_insert      = s_valid_insert[sel];
        s_ready_insert[sel] = m_ready_insert;
      end
      ST_PAYLOAD: begin
        m_valid_in      = s_valid_in[sel];
        s_ready_in[sel] = m_ready_in;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    sel_nxt    = sel;
    rr_ptr_nxt = rr_ptr;
    grant_nxt  = grant;
    case (state)
      ST_IDLE: begin
        if (|s_valid_insert) begin
          state_nxt = ST_HEADER;
          sel_nxt   = arb_idx;
          grant_nxt = arb_gnt;
        end
      end
      ST_HEADER: begin
        if (m_valid_insert && m_ready_insert) state_nxt = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        if (m_valid_in && m_ready_in && m_last_in) begin
          state_nxt  = ST_IDLE;
          grant_nxt  = '0;
          rr_ptr_nxt = (sel == SEL_W'(NUM_SRC - 1)) ? '0 : sel + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      sel    <= '0;
      rr_ptr <= '0;
      grant  <= '0;
    end else begin
      state  <= state_nxt;
      sel    <= sel_nxt;
      rr_ptr <= rr_ptr_nxt;
      grant  <= grant_nxt;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_axis_insert_arbiter.sv
module tb_axis_insert_arbiter;

  localparam int W  = 32;
  localparam int KW = 4;
  localparam int N  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    s_valid_insert = '0;
  logic [N*W-1:0]  s_header_insert = '0;
  logic [N*KW-1:0] s_keep_insert = '0;
  logic [N-1:0]    s_ready_insert;
  logic [N-1:0]    s_valid_in = '0;
  logic [N*W-1:0]  s_data_in = '0;
  logic [N*KW-1:0] s_keep_in = '0;
  logic [N-1:0]    s_last_in = '0;
  logic [N-1:0]    s_ready_in;
  logic            m_valid_insert;
  logic [W-1:0]    m_header_insert;
  logic [KW-1:0]   m_keep_insert;
  logic            m_ready_insert = 1'b1;
  logic            m_valid_in;
  logic [W-1:0]    m_data_in;
  logic [KW-1:0]   m_keep_in;
  logic            m_last_in;
  logic            m_ready_in = 1'b1;
  logic [N-1:0]    grant;
  logic [1:0]      state_dbg;

  axis_insert_arbiter #(.DATA_WD(W), .DATA_BYTE_WD(KW), .NUM_SRC(N)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s_valid_insert  (s_valid_insert),
    .s_header_insert (s_header_insert),
    .s_keep_insert   (s_keep_insert),
    .s_ready_insert  (s_ready_insert),
    .s_valid_in      (s_valid_in),
    .s_data_in       (s_data_in),
    .s_keep_in       (s_keep_in),
    .s_last_in       (s_last_in),
    .s_ready_in      (s_ready_in),
    .m_valid_insert  (m_valid_insert),
    .m_header_insert (m_header_insert),
    .m_keep_insert   (m_keep_insert),
    .m_ready_insert  (m_ready_insert),
    .m_valid_in      (m_valid_in),
    .m_data_in       (m_data_in),
    .m_keep_in       (m_keep_in),
    .m_last_in       (m_last_in),
    .m_ready_in      (m_ready_in),
    .grant           (grant),
    .state_dbg       (state_dbg)
  );

  int checks = 0;
  int errors = 0;
  bit toggle_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- scoreboard queues ----------------
  // header entries {header, keep}; payload entries {data, keep, last}
  logic [W+KW-1:0]   hdr_q0[$], hdr_q1[$];
  logic [W+KW:0]     exp_q0[$], exp_q1[$];
  int                grant_log[$];

  // ---------------- behavioural model + compare ----------------
  // Model: owner = -1 when nobody holds the output, else the source index;
  // in_hdr tells whether the owner is still on its header.
  int m_owner = -1;
  bit m_in_hdr = 1'b0;
  int m_ptr = 0;

  always @(negedge clk) begin
    logic [N-1:0] eg, esri, esrin;
    logic         evi, evin;
    logic [W+KW-1:0] h;
    logic [W+KW:0]   b;
    if (!rst_n) begin
      m_owner = -1; m_in_hdr = 1'b0; m_ptr = 0;
      hdr_q0.delete(); hdr_q1.delete(); exp_q0.delete(); exp_q1.delete();
      check("rst_grant", 64'(grant), 64'd0);
      check("rst_s_ready_insert", 64'(s_ready_insert), 64'd0);
      check("rst_s_ready_in", 64'(s_ready_in), 64'd0);
      check("rst_m_valid", 64'({m_valid_insert, m_valid_in}), 64'd0);
    end else begin
      eg = '0; esri = '0; esrin = '0; evi = 1'b0; evin = 1'b0;
      if (m_owner >= 0) begin
        eg = N'(1) << m_owner;
        if (m_in_hdr) begin
          evi  = s_valid_insert[1'(m_owner)];
          esri = m_ready_insert ? eg : '0;
        end else begin
          evin  = s_valid_in[1'(m_owner)];
          esrin = m_ready_in ? eg : '0;
        end
      end
      check("grant", 64'(grant), 64'(eg));
      check("m_valid_insert", 64'(m_valid_insert), 64'(evi));
      check("m_valid_in", 64'(m_valid_in), 64'(evin));
      check("s_ready_insert", 64'(s_ready_insert), 64'(esri));
      check("s_ready_in", 64'(s_ready_in), 64'(esrin));
      if (evi) begin
        check("m_header_pass", 64'(m_header_insert), 64'(s_header_insert[m_owner*W +: W]));
        if (m_ready_insert) begin
          if (m_owner == 0 && hdr_q0.size() > 0) h = hdr_q0.pop_front();
          else if (m_owner == 1 && hdr_q1.size() > 0) h = hdr_q1.pop_front();
          else h = 'x;
          check("hdr_scoreboard", 64'({m_header_insert, m_keep_insert}), 64'(h));
        end
      end
      if (evin) begin
        check("m_data_pass", 64'(m_data_in), 64'(s_data_in[m_owner*W +: W]));
        if (m_ready_in) begin
          if (m_owner == 0 && exp_q0.size() > 0) b = exp_q0.pop_front();
          else if (m_owner == 1 && exp_q1.size() > 0) b = exp_q1.pop_front();
          else b = 'x;
          check("beat_scoreboard", 64'({m_data_in, m_keep_in, m_last_in}), 64'(b));
        end
      end
      // advance the model to what the next clock edge must produce
      if (m_owner < 0) begin
        for (int k = 0; k < N; k++) begin
          if (m_owner < 0 && s_valid_insert[1'((m_ptr + k) % N)]) begin
            m_owner  = (m_ptr + k) % N;
            m_in_hdr = 1'b1;
            grant_log.push_back(m_owner);
          end
        end
      end else if (m_in_hdr) begin
        if (evi && m_ready_insert) m_in_hdr = 1'b0;
      end else if (evin && m_ready_in && s_last_in[1'(m_owner)]) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
  end

  // ---------------- downstream ready driver ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_ready_in = toggle_en ? ~m_ready_in : 1'b1;
    end
  end

  // ---------------- source driver tasks ----------------
  task automatic wait_hs(input int chan, input int s, input string name);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      if (chan == 0) ok = s_ready_insert[1'(s)];
      else           ok = s_ready_in[1'(s)];
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s timeout src%0d: got no ready expected ready", name, s);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int s, input logic [W-1:0] d, input logic [KW-1:0] k, input logic l);
    s_data_in[s*W +: W]   = d;
    s_keep_in[s*KW +: KW] = k;
    s_last_in[1'(s)]      = l;
  endtask

  task automatic send_pkt(input int s, input int nbeats, input logic [W-1:0] hdr,
                          input logic [KW-1:0] hk, input logic [W-1:0] base, input bit early);
    logic [KW-1:0] k;
    if (s == 0) hdr_q0.push_back({hdr, hk}); else hdr_q1.push_back({hdr, hk});
    for (int i = 0; i < nbeats; i++) begin
      k = (i == nbeats - 1) ? 4'h7 : 4'hF;
      if (s == 0) exp_q0.push_back({base + W'(i), k, i == nbeats - 1});
      else        exp_q1.push_back({base + W'(i), k, i == nbeats - 1});
    end
    s_header_insert[s*W +: W]   = hdr;
    s_keep_insert[s*KW +: KW]   = hk;
    s_valid_insert[1'(s)]       = 1'b1;
    if (early) begin
      set_beat(s, base, 4'hF, nbeats == 1);
      s_valid_in[1'(s)] = 1'b1;
    end
    wait_hs(0, s, "hdr_hs");
    s_valid_insert[1'(s)] = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      set_beat(s, base + W'(i), (i == nbeats - 1) ? 4'h7 : 4'hF, i == nbeats - 1);
      s_valid_in[1'(s)] = 1'b1;
      wait_hs(1, s, "beat_hs");
    end
    s_valid_in[1'(s)] = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int exp_log[10];
    exp_log = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0};
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // single src0 packet, 3 beats
    fork
      send_pkt(0, 3, 32'hA5A5A5A5, 4'b0111, 32'h1000_0000, 1'b0);
      begin
        @(posedge clk);
        #2;
        check("t1_grant", 64'(grant), 64'h1);
        check("t1_m_valid_insert", 64'(m_valid_insert), 64'h1);
        check("t1_m_header", 64'(m_header_insert), 64'hA5A5A5A5);
        check("t1_m_keep", 64'(m_keep_insert), 64'h7);
      end
    join
    repeat (2) @(posedge clk);
    #1;

    // both sources back-to-back, 2-beat packets; rr pointer now at 1
    fork
      begin
        send_pkt(0, 2, 32'h0000_0A01, 4'hF, 32'h2000_0000, 1'b0);
        send_pkt(0, 2, 32'h0000_0A02, 4'hF, 32'h2100_0000, 1'b0);
      end
      begin
        send_pkt(1, 2, 32'h0000_0B01, 4'h3, 32'h3000_0000, 1'b0);
        send_pkt(1, 2, 32'h0000_0B02, 4'h3, 32'h3100_0000, 1'b0);
      end
    join
    repeat (2) @(posedge clk);
    #1;

    // downstream payload ready toggling
    toggle_en = 1'b1;
    send_pkt(1, 4, 32'h0000_0C01, 4'hF, 32'h4000_0000, 1'b0);
    toggle_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // src1 arrives while src0 is in payload; src1 payload valid raised early
    fork
      send_pkt(0, 3, 32'h0000_0D01, 4'hF, 32'h5000_0000, 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1;
        send_pkt(1, 2, 32'h0000_0E01, 4'h1, 32'h6000_0000, 1'b1);
      end
    join
    repeat (2) @(posedge clk);
    #1;

    // reset during src0 beat 2
    hdr_q0.push_back({32'hF00D_0000, 4'hF});
    exp_q0.push_back({32'h7000_0000, 4'hF, 1'b0});
    s_header_insert[0 +: W] = 32'hF00D_0000;
    s_keep_insert[0 +: KW]  = 4'hF;
    s_valid_insert[0]       = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    s_valid_insert[0] = 1'b0;
    set_beat(0, 32'h7000_0000, 4'hF, 1'b0);
    s_valid_in[0] = 1'b1;
    @(posedge clk); #1;
    set_beat(0, 32'h7000_0001, 4'hF, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_grant_async", 64'(grant), 64'h0);
    check("t5_s_ready_in_async", 64'(s_ready_in), 64'h0);
    check("t5_s_ready_insert_async", 64'(s_ready_insert), 64'h0);
    check("t5_m_valid_in_async", 64'(m_valid_in), 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    s_valid_in[0] = 1'b0;
    send_pkt(0, 2, 32'h0000_0F01, 4'hF, 32'h8000_0000, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    check("grant_log_len", 64'(grant_log.size()), 64'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < grant_log.size()) check("grant_order", 64'(grant_log[i]), 64'(exp_log[i]));
    end
    check("hdr_q_empty", 64'(hdr_q0.size() + hdr_q1.size()), 64'd0);
    check("exp_q_empty", 64'(exp_q0.size() + exp_q1.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
